input_buffer_fifo: RTL and testbench
====================================

// Module: input_buffer_fifo
// PURPOSE
//  Per-port flit input buffer. Sits directly upstream of the router arbiter (one instance per N/S/W/E/L port).
//  Accepts flits from the link, holds them in a first-word-fall-through FIFO, and presents the head flit to the
//  arbiter: header address on the low byte, plus empty status. Consumes the arbiter's read strobe.
//  Returns one credit upstream per flit drained, so the upstream credit counter never overruns the buffer.
// PARAMETERS
//  DATA_WIDTH  16  flit width in bits; head flit bits [7:0] carry the YX destination address
//  DEPTH       4   FIFO entries; power of two, >= 2; also the upstream initial credit count
//  CNT_W       $clog2(DEPTH+1)  occupancy counter width (derived, not overridden)
// PORTS
//  clk            in   1           single clock, all state on rising edge
//  reset          in   1           asynchronous, active-low (0 = reset asserted)
//  ib_data_i      in   DATA_WIDTH  flit from link
//  ib_write_i     in   1           link write strobe, one flit per cycle
//  ib_read_i      in   1           arbiter read strobe (arbiter's per-input read output)
//  ib_data_o      out  DATA_WIDTH  head flit, valid whenever ib_empty_o=0 (FWFT)
//  ib_addr_o      out  8           ib_data_o[7:0], header address to the YX processor
//  ib_empty_o     out  1           1 = no flits held
//  ib_full_o      out  1           1 = DEPTH flits held
//  ib_count_o     out  CNT_W       current occupancy 0..DEPTH
//  ib_credit_o    out  1           one-cycle credit pulse to the upstream credit counter
// BEHAVIOUR
//  Reset (reset=0, async): wr_ptr=rd_ptr=0, count=0, ib_empty_o=1, ib_full_o=0, ib_count_o=0, ib_credit_o=0,
//    ib_data_o=0. Storage array is not reset. Release is sampled on the next clk edge.
//  Storage: DEPTH x DATA_WIDTH regs; wr_ptr/rd_ptr are log2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//  Write accepted = ib_write_i & (~full | rd_acc). Data goes to mem[wr_ptr], then wr_ptr++.
//  Read accepted (rd_acc) = ib_read_i & ~empty. Then rd_ptr++.
//  ib_data_o = mem[rd_ptr] combinationally (0 when empty). A written flit is visible on ib_data_o the cycle after the write.
//    No same-cycle bypass.
//  count: +1 on write only, -1 on read only, unchanged on both or neither.
//    empty = (count==0), full = (count==DEPTH); both are decoded from registered count.
//  Boundary cases:
//    - write while full, no read: flit dropped, state unchanged.
//    - read while empty: ignored, no credit.
//    - read+write while full: both accepted, count stays DEPTH.
//    - read+write while empty: write accepted, read ignored, count -> 1.
//  Credit: ib_credit_o is a registered copy of rd_acc: exactly one 1-cycle pulse, 1 cycle after each accepted read.
//    Back-to-back reads give back-to-back pulses.
//  Latency: link write -> ib_empty_o falls: 1 cycle. Arbiter read -> credit upstream: 1 cycle.
//  Reset mid-packet: all flits discarded and no credits emitted. Upstream counter must also be reset to DEPTH.
//  No packet awareness here; packet boundaries are tracked by the arbiter's packet tracker.
// CONFIGURATION
//  IB_ERR_CHECK_EN defined: adds outputs ib_ovf_o and ib_unf_o (1 bit each, reset 0).
//    ib_ovf_o sets on a dropped write to a full buffer. ib_unf_o sets on a read of an empty buffer.
//    Both are sticky until reset. Under simulation, $error is also issued on each event.
//  IB_ERR_CHECK_EN undefined: ports are absent, no extra logic; dropped writes and ignored reads are silent.
// TESTING
//  T1 reset: assert reset=0 mid-traffic -> immediately empty=1, full=0, count=0, credit=0. After release, first read gives no credit.
//  T2 fill/drain DEPTH=4: write 16'h0011,0022,0033,0044 -> full=1, count=4, ib_addr_o=8'h11.
//    Then 4 reads -> data 0011..0044 in order, 4 credit pulses each 1 cycle after its read, empty=1.
//  T3 wrap: 10 cycles of simultaneous write+read at count=2 -> count stays 2, order preserved across pointer wrap.
//    10 credits emitted.
//  T4 full boundary: count=4, write 16'hBEEF with no read -> dropped, count=4 (ib_ovf_o=1 if IB_ERR_CHECK_EN).
//    Same cycle with read=1 -> accepted, BEEF appears at head after 3 more reads.
//  T5 empty boundary: empty, read=1 & write 16'h00A5 same cycle -> no credit, count=1.
//    Next cycle empty=0, ib_addr_o=8'hA5 (ib_unf_o=1 if IB_ERR_CHECK_EN).
//  T6 arbiter handshake: drive read only when empty=0, against a model upstream credit counter initialised to 4.
//    Random writes gated by credits for 1000 cycles -> no drops, counter never <0 or >4, scoreboard matches.

Source files
------------

// File: rtl/input_buffer_fifo.sv
// Per-port first-word-fall-through flit buffer with one credit pulse returned per drained flit.
// Define IB_ERR_CHECK_EN to add sticky overflow/underflow flags (ib_ovf_o, ib_unf_o).
module input_buffer_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] ib_data_i,
  input  logic                  ib_write_i,
  input  logic                  ib_read_i,
  output logic [DATA_WIDTH-1:0] ib_data_o,
  output logic [7:0]            ib_addr_o,
  output logic                  ib_empty_o,
  output logic                  ib_full_o,
  output logic [CNT_W-1:0]      ib_count_o,
  output logic                  ib_credit_o
`ifdef IB_ERR_CHECK_EN
  ,
  output logic                  ib_ovf_o,
  output logic                  ib_unf_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  empty;
  logic                  full;
  logic                  rd_acc;
  logic                  wr_acc;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign rd_acc = ib_read_i & ~empty;
  // A full buffer still takes a write when the head leaves in the same cycle.
  assign wr_acc = ib_write_i & (~full | rd_acc);

  // NOTE: storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= ib_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ib_credit_o <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ib_credit_o <= rd_acc;
    end
  end

  assign ib_data_o  = empty ? '0 : mem[rd_ptr];
  assign ib_addr_o  = ib_data_o[7:0];
  assign ib_empty_o = empty;
  assign ib_full_o  = full;
  assign ib_count_o = count;

`ifdef IB_ERR_CHECK_EN
  logic ovf_evt;
  logic unf_evt;

  assign ovf_evt = ib_write_i & ~wr_acc;
  assign unf_evt = ib_read_i & empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ib_ovf_o <= 1'b0;
      ib_unf_o <= 1'b0;
    end else begin
      if (ovf_evt) ib_ovf_o <= 1'b1;
      if (unf_evt) ib_unf_o <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset && ovf_evt) $error("input_buffer_fifo: write dropped, buffer full");
    if (reset && unf_evt) $error("input_buffer_fifo: read of empty buffer ignored");
  end
`endif
`endif

endmodule

// File: tb/tb_input_buffer_fifo.sv
// Directed bench for input_buffer_fifo: queue scoreboard of accepted flits plus a model
// upstream credit counter for the randomised arbiter handshake.
module tb_input_buffer_fifo;

  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 4;
  localparam int CNT_W      = $clog2(DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [DATA_WIDTH-1:0] ib_data_i;
  logic                  ib_write_i;
  logic                  ib_read_i;
  logic [DATA_WIDTH-1:0] ib_data_o;
  logic [7:0]            ib_addr_o;
  logic                  ib_empty_o;
  logic                  ib_full_o;
  logic [CNT_W-1:0]      ib_count_o;
  logic                  ib_credit_o;

  int unsigned           tests = 0;
  int unsigned           fails = 0;
  logic [DATA_WIDTH-1:0] sb [$];
  logic                  last_wr;
  int                    credits;

  input_buffer_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .ib_data_i  (ib_data_i),
    .ib_write_i (ib_write_i),
    .ib_read_i  (ib_read_i),
    .ib_data_o  (ib_data_o),
    .ib_addr_o  (ib_addr_o),
    .ib_empty_o (ib_empty_o),
    .ib_full_o  (ib_full_o),
    .ib_count_o (ib_count_o),
    .ib_credit_o(ib_credit_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, advance one edge, then compare every output with the model.
  task automatic cycle(input logic w, input logic [DATA_WIDTH-1:0] d, input logic r);
    logic                  m_rd;
    logic                  m_wr;
    logic [DATA_WIDTH-1:0] head;
    ib_write_i = w;
    ib_data_i  = d;
    ib_read_i  = r;
    m_rd = r && (sb.size() != 0);
    m_wr = w && ((sb.size() < DEPTH) || m_rd);
    last_wr = m_wr;
    @(posedge clk);
    #1;
    if (m_rd) void'(sb.pop_front());
    if (m_wr) sb.push_back(d);
    head = (sb.size() != 0) ? sb[0] : '0;
    check("credit", 32'(ib_credit_o), 32'(m_rd));
    check("count",  32'(ib_count_o),  32'(sb.size()));
    check("empty",  32'(ib_empty_o),  32'(sb.size() == 0));
    check("full",   32'(ib_full_o),   32'(sb.size() == DEPTH));
    check("data",   32'(ib_data_o),   32'(head));
    check("addr",   32'(ib_addr_o),   32'(head[7:0]));
    ib_write_i = 1'b0;
    ib_read_i  = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_empty"},  32'(ib_empty_o),  32'd1);
    check({tag, "_full"},   32'(ib_full_o),   32'd0);
    check({tag, "_count"},  32'(ib_count_o),  32'd0);
    check({tag, "_credit"}, 32'(ib_credit_o), 32'd0);
    check({tag, "_data"},   32'(ib_data_o),   32'd0);
  endtask

  initial begin
    reset      = 1'b0;
    ib_data_i  = '0;
    ib_write_i = 1'b0;
    ib_read_i  = 1'b0;
    #12;
    check_reset_state("por");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // T1: asynchronous reset in the middle of traffic, right after a credit was issued
    cycle(1'b1, 16'h0101, 1'b0);
    cycle(1'b1, 16'h0202, 1'b0);
    cycle(1'b1, 16'h0303, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_state("t1_async");
    sb.delete();
    @(posedge clk);
    #1;
    check_reset_state("t1_hold");
    reset = 1'b1;
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0);

    // T2: fill to full, then drain in order with one credit per read
    cycle(1'b1, 16'h0011, 1'b0);
    cycle(1'b1, 16'h0022, 1'b0);
    cycle(1'b1, 16'h0033, 1'b0);
    cycle(1'b1, 16'h0044, 1'b0);
    check("t2_full", 32'(ib_full_o), 32'd1);
    check("t2_addr", 32'(ib_addr_o), 32'h11);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0);

    // T3: simultaneous write+read at count 2 across several pointer wraps
    cycle(1'b1, 16'h3A00, 1'b0);
    cycle(1'b1, 16'h3A01, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'h3B00 + 16'(i), 1'b1);
    check("t3_count", 32'(ib_count_o), 32'd2);

    // T4: full boundary, dropped write and then write+read while full
    cycle(1'b1, 16'h3C00, 1'b0);
    cycle(1'b1, 16'h3C01, 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b0);
    check("t4_dropped", 32'(last_wr), 32'd0);
    cycle(1'b1, 16'hBEEF, 1'b1);
    check("t4_accepted", 32'(last_wr), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0000, 1'b1);
    check("t4_head", 32'(ib_data_o), 32'hBEEF);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0);

    // T5: write+read while empty, the read is ignored
    cycle(1'b1, 16'h00A5, 1'b1);
    check("t5_addr", 32'(ib_addr_o), 32'hA5);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0);

    // T6: credit-gated random writes against an arbiter that reads only when not empty
    credits = DEPTH;
    for (int i = 0; i < 1000; i++) begin
      logic w;
      logic r;
      w = (credits > 0) && ($urandom_range(0, 2) != 0);
      r = !ib_empty_o && ($urandom_range(0, 2) != 0);
      if (w) credits--;
      cycle(w, 16'($urandom), r);
      if (w) check("t6_nodrop", 32'(last_wr), 32'd1);
      if (ib_credit_o) credits++;
      check("t6_credit_range", 32'((credits >= 0) && (credits <= DEPTH)), 32'd1);
      check("t6_credit_balance", 32'(credits + int'(sb.size())), 32'(DEPTH));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
